// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_VAL_DEF = 1999;
  localparam int BCD_W       = 13;
  localparam int DIGIT_W     = 4;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added before the shift.
module bcd_adj3
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= DIGIT_W'(5)) ? i_digit + DIGIT_W'(3) : i_digit;

endmodule

// File: rtl/bin2bcd_fsmd.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the 4-digit display stage.
//   state | meaning
//   IDLE  | ready high, waiting for start
//   OP    | one adjust+shift per cycle, BIN_W cycles
//   DONE  | done_tick high, bcd/ovf just loaded
module bin2bcd_fsmd
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W   = 11,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic             o_ready,
  output logic             o_done_tick,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_ovf
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  state_t             r_state;
  logic [BIN_W-1:0]   r_bin;
  logic [15:0]        r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_next;

  logic [15:0]        w_adj;
  logic [15:0]        w_work_next;

  for (genvar g = 0; g < 4; g++) begin : g_adj
    bcd_adj3 u_adj (
      .i_digit(r_work[g*DIGIT_W +: DIGIT_W]),
      .o_digit(w_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign w_work_next = {w_adj[14:0], r_bin[BIN_W-1]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_bin       <= '0;
      r_work      <= '0;
      r_cnt       <= '0;
      r_ovf_next  <= 1'b0;
      o_ready     <= 1'b1;
      o_done_tick <= 1'b0;
      o_bcd       <= '0;
      o_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_done_tick <= 1'b0;
          if (i_start) begin
            r_bin      <= (i_bin > MAX_BIN) ? MAX_BIN : i_bin;
            r_ovf_next <= (i_bin > MAX_BIN);
            r_work     <= '0;
            r_cnt      <= CNT_W'(BIN_W);
            o_ready    <= 1'b0;
            r_state    <= OP;
          end else begin
            o_ready <= 1'b1;
          end
        end
        OP: begin
          r_work <= w_work_next;
          // w_adj[15] is always 0 after saturation, so recycling it into the LSB equals a zero fill
          r_bin  <= {r_bin[BIN_W-2:0], w_adj[15]};
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            o_bcd       <= w_work_next[BCD_W-1:0];
            o_ovf       <= r_ovf_next;
            o_done_tick <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          o_done_tick <= 1'b0;
          o_ready     <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          o_done_tick <= 1'b0;
          o_ready     <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_fsmd.sv
// Directed bench for bin2bcd_fsmd: latency, saturation, ignored starts, reset abort, back-to-back sweep.
module tb_bin2bcd_fsmd;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] bin;
  logic        ready;
  logic        done;
  logic [12:0] bcd;
  logic        ovf;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin2bcd_fsmd dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_bin      (bin),
    .o_ready    (ready),
    .o_done_tick(done),
    .o_bcd      (bcd),
    .o_ovf      (ovf)
  );

  function automatic logic [12:0] ref_bcd(input int v);
    return {1'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic convert(input logic [10:0] v, input logic [12:0] eb, input logic eo,
                         input string tag);
    int   cyc;
    logic seen;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    cyc   = 0;
    seen  = 1'b0;
    while (!seen && cyc < 30) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) seen = 1'b1;
      else      check({tag, " ready_op"}, 32'(ready), 32'd0);
    end
    check({tag, " latency"}, cyc, 32'd12);
    check({tag, " bcd"}, 32'(bcd), 32'(eb));
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
    check({tag, " ready_done"}, 32'(ready), 32'd0);
    @(negedge clk);
    check({tag, " ready_after"}, 32'(ready), 32'd1);
    check({tag, " done_once"}, 32'(done), 32'd0);
    check({tag, " bcd_hold"}, 32'(bcd), 32'(eb));
  endtask

  initial begin
    int          cyc;
    int          n_done;
    int          last_done;
    int          next_k;
    int          q[$];
    int          e;

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst ready", 32'(ready), 32'd1);
    check("rst done",  32'(done),  32'd0);
    check("rst bcd",   32'(bcd),   32'd0);
    check("rst ovf",   32'(ovf),   32'd0);

    // reset and start together: reset must win and stay in IDLE
    reset = 1'b1; start = 1'b1; bin = 11'd77;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_vs_start ready", 32'(ready), 32'd1);

    convert(11'd0,    13'h0000, 1'b0, "bin0");
    convert(11'd1234, 13'h1234, 1'b0, "bin1234");
    convert(11'd1999, 13'h1999, 1'b0, "bin1999");
    convert(11'd2047, 13'h1999, 1'b1, "bin2047");
    convert(11'd7,    13'h0007, 1'b0, "bin7");

    // start pulse during OP is ignored
    @(negedge clk);
    bin = 11'd500; start = 1'b1;
    cyc = 0; n_done = 0;
    while (cyc < 30) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 5) begin start = 1'b1; bin = 11'd9; end
      if (cyc <= 12) check("midop ready", 32'(ready), 32'd0);
      if (done) begin
        n_done++;
        check("midop bcd", 32'(bcd), 32'h0500);
        check("midop latency", cyc, 32'd12);
      end
    end
    check("midop done_count", n_done, 32'd1);
    check("midop bcd_hold", 32'(bcd), 32'h0500);

    // reset during OP aborts the conversion and clears the result
    @(negedge clk);
    bin = 11'd1500; start = 1'b1;
    cyc = 0; n_done = 0;
    while (cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) n_done++;
      if (cyc == 6) reset = 1'b1;
      if (cyc == 7) begin
        reset = 1'b0;
        check("abort ready", 32'(ready), 32'd1);
        check("abort bcd",   32'(bcd),   32'd0);
        check("abort ovf",   32'(ovf),   32'd0);
      end
    end
    check("abort done_count", n_done, 32'd0);
    convert(11'd42, 13'h0042, 1'b0, "bin42");

    // start held high, bin stepping 0..1999 per acceptance
    @(negedge clk);
    cyc = 0; n_done = 0; last_done = -1; next_k = 0;
    while (cyc < 2000 * 13 + 100) begin
      if (done) begin
        e = (q.size() > 0) ? q.pop_front() : -1;
        check("sweep bcd", 32'(bcd), (e < 0) ? 32'hFFFF : 32'(ref_bcd(e)));
        check("sweep ovf", 32'(ovf), 32'd0);
        if (last_done >= 0) check("sweep spacing", cyc - last_done, 32'd13);
        last_done = cyc;
        n_done++;
      end
      if (ready && next_k < 2000) begin
        start = 1'b1;
        bin   = 11'(next_k);
        q.push_back(next_k);
        next_k++;
      end
      if (next_k == 2000 && q.size() == 0) break;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("sweep done_count", n_done, 32'd2000);

    repeat (20) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
